hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage pipelined RISC-V core. It drives stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and generates EX-stage forwarding selects. It also runs a data-memory wait-state FSM that freezes the pipeline while a slow data memory is busy, with a timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready memory stall cycles before error; legal range is 2 or more.
CNT_W, $clog2(MEM_TIMEOUT)+1, width of the internal wait counter (derived, not overridden).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Rs1D  in  5  rs1 of the instruction in Decode
Rs2D  in  5  rs2 of the instruction in Decode
Rs1E  in  5  rs1 of the instruction in Execute
Rs2E  in  5  rs2 of the instruction in Execute
RdE  in  5  rd of the instruction in Execute
RdM  in  5  rd of the instruction in Memory
RdW  in  5  rd of the instruction in Writeback
RegWriteM  in  1  Memory-stage instruction writes the register file
RegWriteW  in  1  Writeback-stage instruction writes the register file
LoadE  in  1  Execute-stage instruction is a load (ResultSrcE selects memory)
PCSrcE  in  1  branch/jump taken, resolved in Execute
MemReqM  in  1  Memory-stage instruction accesses data memory
MemReadyM  in  1  data memory completes the access this cycle
ForwardAE  out  2  srcA select: 00 = regfile, 01 = Writeback result, 10 = ALUResultM
ForwardBE  out  2  srcB select, same encoding as ForwardAE
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
StallM  out  1  hold EX/MEM
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushW  out  1  load a bubble (RegWrite=0) into MEM/WB
MemErr  out  1  sticky memory timeout error

Behaviour:
- Forwarding (combinational), for each of Rs1E and Rs2E:
  - 10 if RegWriteM, RdM!=0 and RdM==RsXE.
  - Otherwise 01 if RegWriteW, RdW!=0 and RdW==RsXE.
  - Otherwise 00. Memory-stage forwarding has priority over Writeback.
- Load-use hazard: lwStall = LoadE & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
- Memory FSM states:
  - M_IDLE, cnt=0: MemReqM & !MemReadyM sets memStall=1 the same cycle; next state M_WAIT with cnt=1. Otherwise stay in M_IDLE.
  - M_WAIT: memStall = !MemReadyM.
    - MemReadyM: next state M_IDLE, cnt=0, and the stalls drop the same cycle.
    - !MemReadyM and cnt==MEM_TIMEOUT-1: next state M_ERR.
    - Otherwise cnt++.
  - Net effect: M_ERR is entered after exactly MEM_TIMEOUT consecutive stalled cycles.
  - M_ERR: absorbing state; memStall=1 and MemErr=1; only rst exits.
- Priority: memStall > branch redirect > lwStall.
  - memStall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. A branch in Execute stays frozen and resolves when the stall ends.
  - Otherwise PCSrcE: FlushD=1, FlushE=1, StallF=StallD=0. This case includes a coincident lwStall, because the Decode instruction is discarded.
  - Otherwise lwStall: StallF=StallD=1, FlushE=1; 1-cycle bubble.
  - Otherwise all stall and flush outputs are 0.
- MemErr = (state==M_ERR). It is registered, so there is no glitch.
- Reset, including in the middle of a wait: the next edge gives M_IDLE and cnt=0. While rst=1: MemErr=0, all stalls=0, FlushD=FlushE=1, FlushW=1. Forwarding stays purely combinational.
- The controller adds no pipeline latency. Only the FSM and counter are sequential.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs StallCycles[31:0], FlushCount[31:0] and LoadUseCount[31:0], all saturating and cleared by rst.
  - StallCycles increments on every cycle with StallF=1.
  - FlushCount increments on cycles with PCSrcE taking effect (not masked by memStall).
  - LoadUseCount increments on effective lwStall cycles.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - mem_state_t enum: M_IDLE, M_WAIT, M_ERR.
- One sub-module, mem_wait_fsm, contains the state register, the counter and the memStall/MemErr generation. The top level holds forwarding, lwStall and the priority logic.

Test Plan:
- Forward priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=5 -> ForwardAE=10. Then RdM=0 -> ForwardAE=01. Then RegWriteW=0 -> 00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for that cycle. Next cycle with LoadE=0 -> all 0. With RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 with the lwStall conditions true -> FlushD=FlushE=1, StallF=StallD=0.
- Wait states: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF/D/E/M and FlushW high for exactly 3 cycles. The 4th cycle has no stall; state returns to M_IDLE; a PCSrcE held during the stall flushes only in the 4th cycle.
- Timeout: MEM_TIMEOUT=4, MemReadyM never asserted -> 4 stalled cycles, then MemErr=1 and stalls stay 1 indefinitely. A later MemReadyM=1 has no effect. Asserting rst clears MemErr at the next edge.
- Reset mid-wait: rst pulsed on the 2nd M_WAIT cycle -> M_IDLE, cnt=0, MemErr=0. A following request with MemReadyM=1 produces no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Used by hazard_ctrl and mem_wait_fsm.
package hazard_pkg;

    localparam int         REG_W    = 5;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_WAIT = 2'b01,
        M_ERR  = 2'b10
    } mem_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = 7'b000_0000;

    // The Memory-stage producer is younger than Writeback, so it wins the tie.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] rs,
        input logic             reg_write_m,
        input logic [REG_W-1:0] rd_m,
        input logic             reg_write_w,
        input logic [REG_W-1:0] rd_w
    );
        fwd_sel_t sel;
        if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    function automatic logic load_use(
        input logic             load_e,
        input logic [REG_W-1:0] rd_e,
        input logic [REG_W-1:0] rs1_d,
        input logic [REG_W-1:0] rs2_d
    );
        return load_e && (rd_e != REG_ZERO) && ((rs1_d == rd_e) || (rs2_d == rd_e));
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state sequencer with timeout watchdog.
// Raises o_mem_stall while an access is outstanding; o_mem_err is sticky until reset.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_mem_req,
    input  logic i_mem_ready,
    output logic o_mem_stall,
    output logic o_mem_err
);

    localparam int               CNT_W       = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_t       r_state;
    mem_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_mem_stall;

    // State, wait counter and sticky error flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= M_IDLE;
            r_cnt   <= CNT_ZERO;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= (w_state_nxt == M_ERR);
        end
    end

    // Next-state, counter and stall decode; the idle-cycle stall counts as the first wait cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_stall = 1'b0;
        case (r_state)
            M_IDLE: begin
                if (i_mem_req && !i_mem_ready) begin
                    w_mem_stall = 1'b1;
                    w_state_nxt = M_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_state_nxt = M_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            end
            M_WAIT: begin
                w_mem_stall = !i_mem_ready;
                if (i_mem_ready) begin
                    w_state_nxt = M_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_state_nxt = M_ERR;
                    w_cnt_nxt   = r_cnt;
                end else begin
                    w_state_nxt = M_WAIT;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            M_ERR: begin
                w_mem_stall = 1'b1;
                w_state_nxt = M_ERR;
                w_cnt_nxt   = r_cnt;
            end
            default: begin
                w_mem_stall = 1'b0;
                w_state_nxt = M_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign o_mem_stall = w_mem_stall;
    assign o_mem_err   = r_err;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and memory wait-state control for the 5-stage RISC-V pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       LoadE,
    input  logic       PCSrcE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
`ifdef HAZARD_PERF_EN
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount,
    output logic [31:0] LoadUseCount,
`endif
    output logic       MemErr
);

    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;
    logic     w_lw_stall;
    logic     w_mem_stall;
    logic     w_mem_err;
    ctrl_t    w_ctrl;

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_req   (MemReqM),
        .i_mem_ready (MemReadyM),
        .o_mem_stall (w_mem_stall),
        .o_mem_err   (w_mem_err)
    );

    assign w_fwd_a    = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_fwd_b    = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_lw_stall = load_use(LoadE, RdE, Rs1D, Rs2D);

    // Stall/flush priority; a taken branch discards the Decode instruction, so it beats load-use.
    always_comb begin
        w_ctrl = CTRL_NONE;
        if (rst) begin
            w_ctrl.flush_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
            w_ctrl.flush_w = 1'b1;
        end else if (w_mem_stall) begin
            w_ctrl.stall_f = 1'b1;
            w_ctrl.stall_d = 1'b1;
            w_ctrl.stall_e = 1'b1;
            w_ctrl.stall_m = 1'b1;
            w_ctrl.flush_w = 1'b1;
        end else if (PCSrcE) begin
            w_ctrl.flush_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
        end else if (w_lw_stall) begin
            w_ctrl.stall_f = 1'b1;
            w_ctrl.stall_d = 1'b1;
            w_ctrl.flush_e = 1'b1;
        end else begin
            w_ctrl = CTRL_NONE;
        end
    end

    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;
    assign StallF    = w_ctrl.stall_f;
    assign StallD    = w_ctrl.stall_d;
    assign StallE    = w_ctrl.stall_e;
    assign StallM    = w_ctrl.stall_m;
    assign FlushD    = w_ctrl.flush_d;
    assign FlushE    = w_ctrl.flush_e;
    assign FlushW    = w_ctrl.flush_w;
    // The error flag is already a flop; masking with rst keeps it low for the whole reset window.
    assign MemErr    = w_mem_err && !rst;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] PERF_ONE = 32'd1;

    logic        w_flush_eff;
    logic        w_lw_eff;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;
    logic [31:0] r_load_use_count;

    assign w_flush_eff = !w_mem_stall && PCSrcE;
    assign w_lw_eff    = !w_mem_stall && !PCSrcE && w_lw_stall;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles   <= 32'd0;
            r_flush_count    <= 32'd0;
            r_load_use_count <= 32'd0;
        end else begin
            if (w_ctrl.stall_f && (r_stall_cycles != PERF_MAX)) begin
                r_stall_cycles <= r_stall_cycles + PERF_ONE;
            end
            if (w_flush_eff && (r_flush_count != PERF_MAX)) begin
                r_flush_count <= r_flush_count + PERF_ONE;
            end
            if (w_lw_eff && (r_load_use_count != PERF_MAX)) begin
                r_load_use_count <= r_load_use_count + PERF_ONE;
            end
        end
    end

    assign StallCycles  = r_stall_cycles;
    assign FlushCount   = r_flush_count;
    assign LoadUseCount = r_load_use_count;
`endif

endmodule
